// File: rtl/rf_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_scheduler
// Purpose  : Write-back scheduler for the RegisterFile's single write port.
//            Round-robin arbitration between NUM_REQ write-back sources, a
//            registered write-port stage (wsel/wdata/wen) and a per-register
//            pending-write scoreboard (busy) for issue-stage hazard checks.
// Ports    : clk          - clock, all state changes on posedge
//            rst          - asynchronous active-low reset
//            req_valid    - per-requester write-back pending
//            req_ready    - per-requester grant (combinational)
//            req_wsel     - packed destination registers, slice i = req i
//            req_wdata    - packed write data, slice i = req i
//            reserve_en   - issue stage allocates a destination register
//            reserve_sel  - register being allocated
//            busy         - bit r set while a write to r is outstanding
//            wsel/wdata/wen - registered RegisterFile write port
// Revision : 1.0  initial release
// ============================================================================
module rf_wb_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int NREG    = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*$clog2(NREG)-1:0]   req_wsel,
  input  logic [NUM_REQ*XLEN-1:0]           req_wdata,
  input  logic                              reserve_en,
  input  logic [$clog2(NREG)-1:0]           reserve_sel,
  output logic [NREG-1:0]                   busy,
  output logic [$clog2(NREG)-1:0]           wsel,
  output logic [XLEN-1:0]                   wdata,
  output logic                              wen
);

  localparam int IW = $clog2(NREG);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [PW:0]   c_NREQ = (PW+1)'(NUM_REQ);
  localparam logic [PW-1:0] c_LAST = PW'(NUM_REQ - 1);

  // Registered state
  logic [PW-1:0]   r_ptr;
  logic            r_wen;
  logic [IW-1:0]   r_wsel;
  logic [XLEN-1:0] r_wdata;
  logic [NREG-1:0] r_busy;

  // Combinational
  logic [IW-1:0]   w_sel_arr [NUM_REQ];
  logic [XLEN-1:0] w_dat_arr [NUM_REQ];
  logic [PW:0]     w_sum;
  logic            w_any;
  logic [PW-1:0]   w_idx;
  logic [NUM_REQ-1:0] w_gnt;
  logic [PW-1:0]   w_ptr_nxt;
  logic [NREG-1:0] w_busy_nxt;

  // Split the packed request buses into per-requester slices.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_sel_arr[gi] = req_wsel[gi*IW +: IW];
      assign w_dat_arr[gi] = req_wdata[gi*XLEN +: XLEN];
    end
  endgenerate

  // Round-robin search: visit r_ptr, r_ptr+1, ... (mod NUM_REQ) and grant the
  // first valid requester. Only req_valid and r_ptr feed this path.
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    w_sum = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= c_NREQ) begin
        w_sum = w_sum - c_NREQ;
      end
      if (!w_any && req_valid[w_sum[PW-1:0]]) begin
        w_any = 1'b1;
        w_idx = w_sum[PW-1:0];
      end
    end
  end

  always_comb begin
    w_gnt = '0;
    if (w_any) begin
      w_gnt[w_idx] = 1'b1;
    end
  end

  // Grants are masked while reset is asserted so no requester believes it
  // was consumed by a flop that is being held in reset.
  assign req_ready = w_gnt & {NUM_REQ{rst}};

  assign w_ptr_nxt = (w_idx == c_LAST) ? '0 : (w_idx + 1'b1);

  // Scoreboard next state: clear on commit first, then set, so a reserve of
  // the register being committed keeps the bit for the new in-flight write.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_wen) begin
      w_busy_nxt[r_wsel] = 1'b0;
    end
    if (reserve_en && (reserve_sel != '0)) begin
      w_busy_nxt[reserve_sel] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr   <= '0;
      r_wen   <= 1'b0;
      r_wsel  <= '0;
      r_wdata <= '0;
      r_busy  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_any) begin
        r_ptr   <= w_ptr_nxt;
        r_wsel  <= w_sel_arr[w_idx];
        r_wdata <= w_dat_arr[w_idx];
        // A write to x0 is accepted but never reaches the port.
        r_wen   <= (w_sel_arr[w_idx] != '0);
      end else begin
        r_wen   <= 1'b0;
      end
    end
  end

  assign wen   = r_wen;
  assign wsel  = r_wsel;
  assign wdata = r_wdata;
  assign busy  = r_busy;

endmodule
`default_nettype wire

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
Write-back scheduler for the 32x32 RegisterFile's single write port. It shares the port between NUM_REQ write-back sources (e.g. ALU, load unit) using round-robin arbitration. It drives the port's wsel/wdata/wen from an output register. It also keeps a per-register pending-write scoreboard (busy bits) that the issue stage uses for RAW/WAW hazard checks.

Parameters:
NUM_REQ, 2, number of write-back requesters (2..4)
XLEN, 32, data width; matches RegisterFile
NREG, 32, number of architectural registers; index width is $clog2(NREG)=5

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  requester i has a write-back pending
req_ready  out  NUM_REQ  requester i is granted this cycle (combinational)
req_wsel  in  NUM_REQ*5  destination register of requester i (slice i)
req_wdata  in  NUM_REQ*XLEN  write data of requester i (slice i)
reserve_en  in  1  issue stage allocates a destination register this cycle
reserve_sel  in  5  register being allocated
busy  out  NREG  bit r = 1 while a write to register r is outstanding
wsel  out  5  to RegisterFile.wsel (registered)
wdata  out  XLEN  to RegisterFile.wdata (registered)
wen  out  1  to RegisterFile.wen (registered)

Behaviour:
- Reset (rst=0, asynchronous): wen=0, wsel=0, wdata=0, busy=0, rr_ptr=0.
  - Any buffered write in the output register is discarded.
  - req_ready is 0 while rst=0.
- Arbitration:
  - Combinational, one grant per cycle.
  - Search starts at rr_ptr and proceeds upward modulo NUM_REQ; the first i with req_valid[i]=1 gets req_ready[i]=1. All other ready bits are 0.
  - req_ready never depends on req_wdata or req_wsel.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i] at a posedge.
  - A requester holds valid, wsel and wdata stable until it sees ready.
  - Valid must not drop without a transfer.
- Pointer update: on a transfer from i, rr_ptr <= (i+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- Output stage:
  - The edge that completes a transfer loads wsel <= req_wsel[i] and wdata <= req_wdata[i].
  - wen <= 1 unless req_wsel[i]==0; a write to x0 is consumed but gives wen=0.
  - With no transfer, wen <= 0 and wsel/wdata hold their last value.
  - Latency: transfer at edge N, wen high during cycle N+1, RegisterFile updated at edge N+2, read-back data visible from cycle N+2 (registered read).
  - Throughput: one write per cycle, no bubbles.
- Scoreboard:
  - Set: reserve_en & reserve_sel!=0 sets busy[reserve_sel] at the edge.
  - Clear: wen=1 clears busy[wsel] at the edge on which the RegisterFile commits.
  - Simultaneous set and clear of the same register: set wins, so the new in-flight write keeps the bit.
  - Set and clear of different registers in the same cycle: both apply.
  - busy[0] is constant 0; reserve of x0 is ignored.
  - Re-reserving an already-busy register leaves it busy; there is no counting, and the issue stage must stall on busy for WAW.
- A write-back to a register whose busy bit is 0 is legal: it writes and leaves busy at 0.
- No combinational path from req_* to wsel, wdata or wen.

Test Plan:
- Reset: assert rst=0 mid-stream with wen=1 pending.
  - Required: wen=0, busy=0 and req_ready=0 immediately (asynchronous, before the next edge).
  - After rst=1, the first grant goes to requester 0.
- Single write: req0 wsel=10, wdata=0xABCD_1234.
  - Required: req_ready[0]=1 the same cycle; wen=1 with wsel=10 the next cycle.
  - RegisterFile r10 reads 0xABCD_1234 two cycles after the transfer.
- Round-robin fairness: req0 and req1 both valid continuously with distinct registers (5/0x1111_1111, 6/0x2222_2222, then 7, 8).
  - Required: grants alternate 0,1,0,1 and wen stays high every cycle.
- x0 suppression: req1 wsel=0, wdata=0xDECAFBAD.
  - Required: req_ready[1]=1, wen stays 0, and r0 reads 0.
- Scoreboard: reserve r12, then req0 writes r12=0xFFFF_0000.
  - Required: busy[12]=1 from the edge after reserve until the edge on which wen=1/wsel=12 commits, then 0.
  - Repeat with reserve_sel=12 on that same commit cycle: busy[12] stays 1.
- Random stress: 200 cycles of random valid, register and data per requester, plus random reserves, checked against a reference model.
  - Required: every transfer appears on wsel/wdata exactly once, in grant order.
  - No requester starves beyond NUM_REQ-1 cycles.
  - busy matches the model every cycle.
